// File: rtl/base10_alu_sched_if.sv
// Request/response bus between the requesting engines and base10_alu_sched.
// The master side is a requester pool and the slave side is the scheduler.
interface base10_alu_sched_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [4*NUM_REQ-1:0]  req_op;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [15:0]           rsp_result;
    logic                  rsp_error;

    modport master (
        output req_valid, req_op, req_a, req_b,
        input  req_ready, rsp_valid, rsp_result, rsp_error
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        output req_ready, rsp_valid, rsp_result, rsp_error
    );
endinterface

// File: rtl/base10_alu_sched.sv
// Round-robin scheduler sharing one base10_alu among NUM_REQ requesters.
// Define ALU_SCHED_TIMEOUT_EN to build the WAIT-state watchdog (TIMEOUT_CYCLES).
module base10_alu_sched #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                clk,
    input  logic                reset,
    base10_alu_sched_if.slave   bus,
    output logic                busy,
    output logic [15:0]         ops_done,
    output logic                alu_enable,
    output logic [3:0]          alu_operation,
    output logic [15:0]         alu_operand_a,
    output logic [15:0]         alu_operand_b,
    input  logic [15:0]         alu_result,
    input  logic                alu_valid
);

    localparam int IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } state_t;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("base10_alu_sched: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    state_t               state;
    state_t               next_state;
    logic [IDX_W-1:0]     owner;
    logic [IDX_W-1:0]     last_grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_vld;
    logic [3:0]           sel_op;
    logic [15:0]          sel_a;
    logic [15:0]          sel_b;
    logic [NUM_REQ-1:0]   owner_onehot;
    logic                 timeout_hit;

    // Search starts one past the last served requester, so it has lowest priority.
    always_comb begin : arbiter
        logic [IDX_W:0] cand;
        // NOTE: every combinational output gets a default first so no path infers a latch.
        grant_vld     = 1'b0;
        grant_idx     = '0;
        cand          = '0;
        bus.req_ready = '0;
        if (state == IDLE) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = {1'b0, last_grant} + (IDX_W+1)'(k);
                if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                    cand = cand - (IDX_W+1)'(NUM_REQ);
                end
                if (!grant_vld && bus.req_valid[cand[IDX_W-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand[IDX_W-1:0];
                end
            end
        end
        if (grant_vld) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin : payload_mux
        sel_op       = '0;
        sel_a        = '0;
        sel_b        = '0;
        owner_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_op = bus.req_op[4*i +: 4];
                sel_a  = bus.req_a[16*i +: 16];
                sel_b  = bus.req_b[16*i +: 16];
            end
            owner_onehot[i] = (owner == IDX_W'(i));
        end
    end

    always_comb begin : next_state_logic
        next_state = state;
        unique case (state)
            IDLE:    if (grant_vld) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (alu_valid || timeout_hit) next_state = RESPOND;
            RESPOND: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: only control and datapath registers exist here, so all of them take a reset value.
        if (reset) begin
            state          <= IDLE;
            owner          <= '0;
            last_grant     <= IDX_W'(NUM_REQ - 1);
            busy           <= 1'b0;
            ops_done       <= '0;
            alu_enable     <= 1'b0;
            alu_operation  <= '0;
            alu_operand_a  <= '0;
            alu_operand_b  <= '0;
            bus.rsp_valid  <= '0;
            bus.rsp_result <= '0;
        end else begin
            state         <= next_state;
            busy          <= (next_state != IDLE);
            alu_enable    <= (next_state == ISSUE);
            bus.rsp_valid <= (next_state == RESPOND) ? owner_onehot : '0;
            unique case (state)
                IDLE: begin
                    if (grant_vld) begin
                        owner         <= grant_idx;
                        alu_operation <= sel_op;
                        alu_operand_a <= sel_a;
                        alu_operand_b <= sel_b;
                    end
                end
                WAIT: begin
                    if (alu_valid) begin
                        bus.rsp_result <= alu_result;
                    end else if (timeout_hit) begin
                        bus.rsp_result <= '0;
                    end
                end
                RESPOND: begin
                    last_grant <= owner;
                    ops_done   <= ops_done + 16'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_SCHED_TIMEOUT_EN
    logic [15:0] wait_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt      <= '0;
            bus.rsp_error <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + 16'd1 : '0;
            if (state == WAIT) begin
                if (alu_valid) begin
                    bus.rsp_error <= 1'b0;
                end else if (timeout_hit) begin
                    bus.rsp_error <= 1'b1;
                end
            end
        end
    end

    // The counter reads 0 in the first WAIT cycle, so TIMEOUT_CYCLES WAIT cycles end here.
    assign timeout_hit = (state == WAIT) && (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit   = 1'b0;
    assign bus.rsp_error = 1'b0;
`endif

endmodule

// File: tb/tb_base10_alu_sched.sv
// Directed bench for base10_alu_sched with a small behavioural base10_alu model
// (enable sampled, two compute cycles, then a one-cycle valid).
module tb_base10_alu_sched;

    localparam int NUM_REQ = 4;
    localparam int TO      = 15;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_SHL = 4'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        busy;
    logic [15:0] ops_done;
    logic        alu_enable;
    logic [3:0]  alu_operation;
    logic [15:0] alu_operand_a;
    logic [15:0] alu_operand_b;
    logic [15:0] alu_result;
    logic        alu_valid;

    logic [3:0]  op_arr [NUM_REQ];
    logic [15:0] a_arr  [NUM_REQ];
    logic [15:0] b_arr  [NUM_REQ];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    base10_alu_sched_if #(.NUM_REQ(NUM_REQ)) bus ();

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
        assign bus.req_op[4*g +: 4]  = op_arr[g];
        assign bus.req_a[16*g +: 16] = a_arr[g];
        assign bus.req_b[16*g +: 16] = b_arr[g];
    end

    base10_alu_sched #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .busy          (busy),
        .ops_done      (ops_done),
        .alu_enable    (alu_enable),
        .alu_operation (alu_operation),
        .alu_operand_a (alu_operand_a),
        .alu_operand_b (alu_operand_b),
        .alu_result    (alu_result),
        .alu_valid     (alu_valid)
    );

    // Behavioural ALU: results saturate to 0 on underflow, divide-by-zero and illegal opcodes.
    logic [1:0]  alu_cnt;
    logic [15:0] alu_res_q;
    logic        alu_valid_q;
    logic        alu_kill = 1'b0;

    function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return (a < b) ? 16'd0 : a - b;
            OP_MUL:  return 16'(a * b);
            OP_DIV:  return (b == 16'd0) ? 16'd0 : a / b;
            OP_SHL:  return a << b[3:0];
            default: return 16'd0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_cnt     <= '0;
            alu_res_q   <= '0;
            alu_valid_q <= 1'b0;
        end else begin
            alu_valid_q <= 1'b0;
            if (alu_enable) begin
                alu_cnt   <= 2'd1;
                alu_res_q <= alu_fn(alu_operation, alu_operand_a, alu_operand_b);
            end else if (alu_cnt == 2'd1) begin
                alu_cnt <= 2'd2;
            end else if (alu_cnt == 2'd2) begin
                alu_cnt     <= 2'd0;
                alu_valid_q <= 1'b1;
            end
        end
    end

    assign alu_valid  = alu_valid_q & ~alu_kill;
    assign alu_result = alu_res_q;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        reset         = 1'b1;
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Issues one request at a negedge and waits (bounded) for its response pulse.
    task automatic run_op(input int idx, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          output logic [3:0] ready, output int lat, output logic [3:0] rsp,
                          output logic [15:0] res, output logic err, output int pulses);
        op_arr[idx] = op;
        a_arr[idx]  = a;
        b_arr[idx]  = b;
        bus.req_valid      = '0;
        bus.req_valid[idx] = 1'b1;
        #1;
        ready  = bus.req_ready;
        lat    = -1;
        rsp    = '0;
        res    = '0;
        err    = 1'b0;
        pulses = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) bus.req_valid[idx] = 1'b0;
            if (bus.rsp_valid != '0) begin
                pulses++;
                if (lat < 0) begin
                    lat = c;
                    rsp = bus.rsp_valid;
                    res = bus.rsp_result;
                    err = bus.rsp_error;
                end
            end
            if (lat >= 0 && c >= lat + 3) break;
        end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        checks++;
        if ({busy, ops_done, alu_enable, alu_operation} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl: got busy=%b ops_done=%0h en=%b op=%0h, expected all 0",
                     busy, ops_done, alu_enable, alu_operation);
        end
        checks++;
        if ({alu_operand_a, alu_operand_b} !== 32'd0) begin
            failures++;
            $display("FAIL reset_operands: got a=%0h b=%0h, expected 0", alu_operand_a, alu_operand_b);
        end
        checks++;
        if ({bus.rsp_valid, bus.rsp_result, bus.rsp_error, bus.req_ready} !== '0) begin
            failures++;
            $display("FAIL reset_rsp: got rsp_valid=%b result=%0h err=%b ready=%b, expected 0",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_error, bus.req_ready);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [3:0] ready, rsp; logic [15:0] res; logic err; int lat, pulses;
        run_op(0, OP_ADD, 16'd25, 16'd17, ready, lat, rsp, res, err, pulses);
        checks++;
        if (ready !== 4'b0001) begin failures++; $display("FAIL add_ready: got %b expected 0001", ready); end
        checks++;
        if (lat != 5) begin failures++; $display("FAIL add_latency: got %0d expected 5", lat); end
        checks++;
        if (rsp !== 4'b0001) begin failures++; $display("FAIL add_rsp_valid: got %b expected 0001", rsp); end
        checks++;
        if (res !== 16'd42) begin failures++; $display("FAIL add_result: got %0d expected 42", res); end
        checks++;
        if (err !== 1'b0 || pulses != 1) begin
            failures++;
            $display("FAIL add_err_pulses: got err=%b pulses=%0d expected 0 and 1", err, pulses);
        end
        checks++;
        if (ops_done !== 16'd1) begin failures++; $display("FAIL add_ops_done: got %0d expected 1", ops_done); end
    endtask

    task automatic test_sub_div();
        logic [3:0] ready, rsp; logic [15:0] res; logic err; int lat, pulses;
        apply_reset();
        run_op(2, OP_SUB, 16'd5, 16'd9, ready, lat, rsp, res, err, pulses);
        checks++;
        if (ready !== 4'b0100 || rsp !== 4'b0100) begin
            failures++;
            $display("FAIL sub_onehot: got ready=%b rsp=%b expected 0100/0100", ready, rsp);
        end
        checks++;
        if (res !== 16'd0 || lat != 5) begin
            failures++;
            $display("FAIL sub_result: got res=%0d lat=%0d expected 0 and 5", res, lat);
        end
        run_op(2, OP_DIV, 16'd100, 16'd0, ready, lat, rsp, res, err, pulses);
        checks++;
        if (rsp !== 4'b0100 || pulses != 1) begin
            failures++;
            $display("FAIL div_rsp: got rsp=%b pulses=%0d expected 0100 and 1", rsp, pulses);
        end
        checks++;
        if (res !== 16'd0) begin failures++; $display("FAIL div_result: got %0d expected 0", res); end
        checks++;
        if (ops_done !== 16'd2) begin failures++; $display("FAIL subdiv_ops_done: got %0d expected 2", ops_done); end
    endtask

    task automatic test_back_to_back();
        int grant_id [5];
        int grant_cy [5];
        int n = 0;
        int exp_id [5] = '{0, 1, 2, 3, 0};
        reset = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            op_arr[i] = OP_ADD;
            a_arr[i]  = 16'(i);
            b_arr[i]  = 16'd10;
        end
        bus.req_valid = '1;
        @(negedge clk);
        reset = 1'b0;
        for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
            #1;
            if (bus.req_ready != '0) begin
                grant_cy[n] = cyc;
                grant_id[n] = -1;
                for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) grant_id[n] = i;
                checks++;
                if (!$onehot(bus.req_ready)) begin
                    failures++;
                    $display("FAIL b2b_onehot: got ready=%b expected one-hot", bus.req_ready);
                end
                n++;
            end
            @(negedge clk);
        end
        checks++;
        if (n != 5) begin failures++; $display("FAIL b2b_count: got %0d accepts expected 5", n); end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (grant_id[i] != exp_id[i]) begin
                failures++;
                $display("FAIL b2b_order[%0d]: got %0d expected %0d", i, grant_id[i], exp_id[i]);
            end
            if (i > 0) begin
                checks++;
                if (grant_cy[i] - grant_cy[i-1] != 6) begin
                    failures++;
                    $display("FAIL b2b_spacing[%0d]: got %0d expected 6", i, grant_cy[i] - grant_cy[i-1]);
                end
            end
        end
        bus.req_valid = '0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        logic [3:0] ready, rsp; logic [15:0] res; logic err; int lat, pulses;
        int stray = 0;
        op_arr[1] = OP_SHL;
        a_arr[1]  = 16'd7;
        b_arr[1]  = 16'd2;
        bus.req_valid = 4'b0010;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL mid_ready: got %b expected 0010", bus.req_ready);
        end
        @(posedge clk); @(negedge clk);
        bus.req_valid = '0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        checks++;
        if (busy !== 1'b1 || alu_operand_a !== 16'd7 || alu_operation !== OP_SHL) begin
            failures++;
            $display("FAIL mid_inflight: got busy=%b a=%0d op=%0d expected 1, 7, 4", busy, alu_operand_a, alu_operation);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, ops_done, alu_enable, alu_operation, alu_operand_a, alu_operand_b} !== '0) begin
            failures++;
            $display("FAIL mid_async_reset: got busy=%b ops=%0h en=%b op=%0h a=%0h b=%0h expected 0",
                     busy, ops_done, alu_enable, alu_operation, alu_operand_a, alu_operand_b);
        end
        checks++;
        if ({bus.rsp_valid, bus.rsp_result} !== '0) begin
            failures++;
            $display("FAIL mid_rsp_reset: got rsp_valid=%b result=%0h expected 0", bus.rsp_valid, bus.rsp_result);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) stray++;
        end
        checks++;
        if (stray != 0) begin failures++; $display("FAIL mid_no_rsp: got %0d pulses expected 0", stray); end
        run_op(1, OP_SHL, 16'd7, 16'd2, ready, lat, rsp, res, err, pulses);
        checks++;
        if (res !== 16'd28 || rsp !== 4'b0010 || lat != 5) begin
            failures++;
            $display("FAIL mid_resume: got res=%0d rsp=%b lat=%0d expected 28, 0010, 5", res, rsp, lat);
        end
    endtask

`ifdef ALU_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        logic [3:0] ready, rsp; logic [15:0] res; logic err; int lat, pulses;
        apply_reset();
        alu_kill = 1'b1;
        run_op(3, OP_MUL, 16'd6, 16'd7, ready, lat, rsp, res, err, pulses);
        alu_kill = 1'b0;
        checks++;
        if (lat != TO + 2) begin failures++; $display("FAIL to_latency: got %0d expected %0d", lat, TO + 2); end
        checks++;
        if (rsp !== 4'b1000 || err !== 1'b1 || res !== 16'd0) begin
            failures++;
            $display("FAIL to_rsp: got rsp=%b err=%b res=%0d expected 1000, 1, 0", rsp, err, res);
        end
    endtask
`endif

    task automatic test_ops_wrap();
        logic [3:0] ready, rsp; logic [15:0] res; logic err; int lat, pulses;
        apply_reset();
        force dut.ops_done = 16'hFFFF;
        #1;
        release dut.ops_done;
        run_op(0, OP_ADD, 16'd1000, 16'd2345, ready, lat, rsp, res, err, pulses);
        checks++;
        if (res !== 16'd3345) begin failures++; $display("FAIL wrap_result: got %0d expected 3345", res); end
        checks++;
        if (ops_done !== 16'd0) begin failures++; $display("FAIL wrap_ops_done: got %0h expected 0", ops_done); end
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            op_arr[i] = '0;
            a_arr[i]  = '0;
            b_arr[i]  = '0;
        end
        bus.req_valid = '0;
        test_reset();
        test_add();
        test_sub_div();
        test_back_to_back();
        test_reset_mid_op();
`ifdef ALU_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        test_ops_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/base10_alu_sched.md
# base10_alu_sched

Round-robin scheduler that shares one `base10_alu` instance among `NUM_REQ` independent requesters. It accepts one operation at a time through a valid/ready handshake, sequences the ALU's enable/valid protocol, and returns the result to the winning requester as a one-cycle response pulse. It sits between the requesting engines and the single ALU instance, and is the only driver of the ALU's `enable`, `operation`, `operand_a` and `operand_b` inputs.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `TIMEOUT_CYCLES`, 15: WAIT-state watchdog limit in cycles. Only used when `ALU_SCHED_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high. The ALU's `reset` is tied to the same net.
- `req_valid` in NUM_REQ: per-requester request.
- `req_ready` out NUM_REQ: one-hot accept for the winning requester; at most one bit is set.
- `req_op` in 4*NUM_REQ: packed opcodes, requester i at `[4i+3:4i]`.
- `req_a` in 16*NUM_REQ: packed operand A, requester i at `[16i+15:16i]`.
- `req_b` in 16*NUM_REQ: packed operand B, same packing as `req_a`.
- `rsp_valid` out NUM_REQ: one-hot, one-cycle response strobe.
- `rsp_result` out 16: result, qualified by `rsp_valid`.
- `rsp_error` out 1: timeout flag, qualified by `rsp_valid`.
- `busy` out 1: high in every state except IDLE.
- `ops_done` out 16: count of completed responses; wraps from 0xFFFF to 0.
- `alu_enable` out 1: drives ALU `enable`.
- `alu_operation` out 4: drives ALU `operation`.
- `alu_operand_a` out 16: drives ALU `operand_a`.
- `alu_operand_b` out 16: drives ALU `operand_b`.
- `alu_result` in 16: from ALU `result`.
- `alu_valid` in 1: from ALU `valid`.

## Operation
- States: IDLE, ISSUE, WAIT, RESPOND. The encoding is 2 bits.
- Reset:
  - State goes to IDLE.
  - All outputs go to 0.
  - The operand/opcode latches go to 0.
  - `last_grant` is set to NUM_REQ-1, so requester 0 has top priority first.
- IDLE:
  - `req_ready` is combinational. It is the first set `req_valid` bit found by searching from `last_grant+1` upward and wrapping modulo NUM_REQ.
  - On a cycle where `req_valid[w] & req_ready[w]`:
    - latch `req_op`, `req_a` and `req_b` slice w into the `alu_*` registers;
    - store w as the current owner;
    - go to ISSUE.
  - With no request, remain in IDLE.
- ISSUE: `alu_enable` is 1 for exactly one cycle, then go to WAIT.
- WAIT:
  - `alu_*` operands stay stable.
  - `alu_enable` is 0.
  - When `alu_valid` is 1, capture `alu_result` and go to RESPOND.
- RESPOND:
  - `rsp_valid[owner]` is 1 for exactly one cycle, with `rsp_result` set to the captured value.
  - `last_grant` is set to owner.
  - `ops_done` increments.
  - Go to IDLE.
- Responses have no back-pressure. A requester must be able to take `rsp_valid` in any cycle.
- Requesters hold `req_valid` and their payload stable until `req_ready` is seen. Dropping `req_valid` before acceptance is legal, and the request is simply not served.
- A requester may re-request in the cycle after its `rsp_valid`.
- `alu_valid` is ignored in every state except WAIT.
- Opcodes pass through unchecked. Illegal opcodes return whatever the ALU produces (0).
- `reset` asserted mid-operation: the scheduler returns to IDLE immediately and the in-flight request is dropped with no response. The ALU is reset on the same net.

## Timing
- Accept cycle is T (IDLE handshake). Then:
  - ISSUE is at T+1;
  - the ALU computes during T+2 and T+3;
  - `alu_valid` is seen at T+4;
  - `rsp_valid` is at T+5.
- Request-accept to response latency is 5 cycles.
- Back-to-back throughput is one operation per 6 cycles: after RESPOND at T+5, the next accept is at T+6.
- The next `alu_enable` never arrives before the ALU's `valid` has cleared.
- `req_ready` is combinational from `req_valid`. All other outputs are registered.

## Configuration
- `ALU_SCHED_TIMEOUT_EN` defined:
  - A counter resets to 0 on entry to WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT_CYCLES` without `alu_valid`, go to RESPOND with `rsp_result`=0 and `rsp_error`=1.
  - A late `alu_valid` arriving after a timeout is ignored.
- `ALU_SCHED_TIMEOUT_EN` undefined:
  - No counter is built.
  - WAIT waits indefinitely.
  - `rsp_error` is tied to 0.

## Test plan
- Reset, then requester 0 submits ADD with a=25, b=17. Required: `req_ready[0]` in the same cycle; `rsp_valid`=4'b0001 with result 42 exactly 5 cycles later; `ops_done`=1.
- Requester 2 submits SUB with a=5, b=9, then DIV with a=100, b=0. Required: results 0 and 0, each pulse on `rsp_valid[2]` only; `ops_done`=2.
- All four requesters assert `req_valid` continuously from reset. Required: grant order 0,1,2,3,0; consecutive accepts exactly 6 cycles apart.
- Requester 1 submits SHL with a=7, b=2, and reset is asserted at T+3. Required: all outputs return to 0 asynchronously; no `rsp_valid` pulse; the next request is served normally.
- With `ALU_SCHED_TIMEOUT_EN` and the ALU `valid` forced to 0, requester 3 submits MUL. Required: `rsp_valid[3]` with `rsp_error`=1 and result 0, at TIMEOUT_CYCLES+2 cycles after accept.
- `ops_done` preloaded via force to 0xFFFF, then one operation completes. Required: `ops_done`=0.
